// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Fetch controller states; the numeric encoding is what appears on fetch_state.
  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    STALL  = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

  // Sequential fetch stride (one 32-bit instruction word).
  localparam logic [63:0] PC_INC = 64'd4;

  // Width of the memory wait-state counter; holds IMEM_WAIT values 0..15.
  localparam int WAIT_W = 4;

  // Redirect target selection: register branch when use_reg is set, else PC-relative.
  function automatic logic [63:0] pick_target(input logic use_reg,
                                              input logic [63:0] br_target,
                                              input logic [63:0] reg_target);
    return use_reg ? reg_target : br_target;
  endfunction

endpackage

// File: rtl/address_adder.sv
// Plain wrapping adder used for PC arithmetic; the sum is taken modulo 2^W.
module address_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Carry out is dropped so the address space wraps.
  assign sum = a + b;

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count enabled events; synchronous clear wins over increment, saturation blocks wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: chooses the next PC, gates IF/ID, issues flushes
// and inserts wait states for a multi-cycle instruction memory.
//
// Handshake: there is no valid/ready pair here. A fetch "completes" in the cycle
// the memory word is usable (FETCH with no wait states, or the last WAIT cycle).
// In that cycle pc_we/if_id_we fire together unless a redirect, halt or stall
// takes priority. Outputs are combinational from state and current inputs; the
// external PC register samples pc_next on the following rising edge.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int IMEM_WAIT = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      pc_cur,
  input  logic             stall_req,
  input  logic             halt_req,
  input  logic             redirect,
  input  logic             redirect_reg,
  input  logic [63:0]      br_target,
  input  logic [63:0]      reg_target,
  output logic [63:0]      pc_next,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [2:0]       fetch_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic              HAS_WAIT  = (IMEM_WAIT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(IMEM_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;
  logic              complete;
  logic              active;
  logic [63:0]       pc_plus4;
  logic              inc_stall;
  logic              inc_redirect;
  logic              inc_instr;

  assign fetch_state = state;

  // Sequential PC goes through the shared address adder so it wraps at 2^64.
  address_adder #(.W(64)) u_pc_inc (
    .a   (pc_cur),
    .b   (PC_INC),
    .sum (pc_plus4)
  );

  // The current fetch word is usable this cycle.
  always_comb begin
    complete = ((state == FETCH) && !HAS_WAIT) ||
               ((state == WAIT) && (wait_cnt == WAIT_ONE));
    active   = (state == FETCH) || (state == WAIT) || (state == STALL);
  end

  // Next-state, PC selection and pipeline-control decision in priority order.
  always_comb begin
    state_nx     = state;
    wait_nx      = wait_cnt;
    pc_next      = pc_cur;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    inc_stall    = 1'b0;
    inc_redirect = 1'b0;
    inc_instr    = 1'b0;

    if (state == BOOT) begin
      // The PC register supplies its own reset value; just start fetching.
      state_nx = FETCH;
      wait_nx  = '0;
    end else if (active) begin
      if (redirect) begin
        // Taken branch wins over everything younger, including halt and stall.
        pc_next      = pick_target(redirect_reg, br_target, reg_target);
        pc_we        = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        state_nx     = FETCH;
        wait_nx      = '0;
        inc_redirect = 1'b1;
      end else if (halt_req) begin
        state_nx = HALTED;
        wait_nx  = '0;
      end else if (stall_req && (complete || (state == STALL))) begin
        // PC is held, so the fetched word stays valid for the release cycle.
        state_nx  = STALL;
        wait_nx   = '0;
        inc_stall = 1'b1;
      end else if (complete || (state == STALL)) begin
        pc_next   = pc_plus4;
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        state_nx  = FETCH;
        wait_nx   = '0;
        inc_instr = 1'b1;
      end else if (state == FETCH) begin
        // Only reachable with wait states configured.
        state_nx = WAIT;
        wait_nx  = WAIT_LOAD;
      end else begin
        wait_nx = wait_cnt - WAIT_ONE;
      end
    end
    // HALTED: defaults hold everything at zero until reset.
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (inc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (inc_redirect),
    .count (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (inc_instr),
    .count (instr_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: one instance with two wait states (table, directed
// corners and random traffic against a reference model) and one with none.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int WS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- instance with wait states ----------------
  logic [63:0] pc_cur, br_target, reg_target, pc_next;
  logic        stall_req, halt_req, redirect, redirect_reg;
  logic        pc_we, if_id_we, if_id_flush, id_ex_flush;
  logic [2:0]  fetch_state;
  logic [31:0] stall_cnt, redirect_cnt, instr_cnt;

  fetch_sequencer #(.IMEM_WAIT(WS), .CNT_W(32)) dut (
    .clk(clk), .reset(rst_n), .pc_cur(pc_cur), .stall_req(stall_req),
    .halt_req(halt_req), .redirect(redirect), .redirect_reg(redirect_reg),
    .br_target(br_target), .reg_target(reg_target), .pc_next(pc_next),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fetch_state(fetch_state),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .instr_cnt(instr_cnt)
  );

  // PC register environment
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc_cur <= 64'd0;
    else if (pc_we) pc_cur <= pc_next;

  // ---------------- instance with no wait states ----------------
  logic [63:0] z_pc_cur, z_pc_next;
  logic [63:0] z_zero64 = 64'd0;
  logic        z_zero = 1'b0;
  logic        z_pc_we, z_if_id_we, z_if_id_flush, z_id_ex_flush;
  logic [2:0]  z_fetch_state;
  logic [31:0] z_stall_cnt, z_redirect_cnt, z_instr_cnt;

  fetch_sequencer #(.IMEM_WAIT(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(rst_n), .pc_cur(z_pc_cur), .stall_req(z_zero),
    .halt_req(z_zero), .redirect(z_zero), .redirect_reg(z_zero),
    .br_target(z_zero64), .reg_target(z_zero64), .pc_next(z_pc_next),
    .pc_we(z_pc_we), .if_id_we(z_if_id_we), .if_id_flush(z_if_id_flush),
    .id_ex_flush(z_id_ex_flush), .fetch_state(z_fetch_state),
    .stall_cnt(z_stall_cnt), .redirect_cnt(z_redirect_cnt), .instr_cnt(z_instr_cnt)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) z_pc_cur <= 64'd0;
    else if (z_pc_we) z_pc_cur <= z_pc_next;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A fetch takes 1+WS cycles; m_left counts cycles still to go in the
  // current fetch, m_stalled means the fetched word is parked.
  bit          m_boot, m_halted, m_stalled;
  int          m_left;
  logic [63:0] m_pc;
  logic [31:0] m_ic, m_rc, m_sc;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_stalled = 0; m_left = 1 + WS;
    m_pc = 64'd0; m_ic = 0; m_rc = 0; m_sc = 0;
  endtask

  // Drive one cycle of inputs, compare the DUT with the model, advance the model.
  task automatic cycle_begin(input logic s, input logic h, input logic r, input logic rr,
                             input logic [63:0] bt, input logic [63:0] rt);
    logic [2:0]  e_state;
    logic        e_we, e_ifid, e_fl;
    logic [63:0] e_next;
    stall_req = s; halt_req = h; redirect = r; redirect_reg = rr;
    br_target = bt; reg_target = rt;
    #1;
    e_we = 0; e_ifid = 0; e_fl = 0; e_next = m_pc;
    if (m_boot) e_state = BOOT;
    else if (m_halted) e_state = HALTED;
    else if (m_stalled) e_state = STALL;
    else if (m_left == 1 + WS) e_state = FETCH;
    else e_state = WAIT;
    chk("m_state", 64'(fetch_state), 64'(e_state));
    chk("m_instr_cnt", 64'(instr_cnt), 64'(m_ic));
    chk("m_redirect_cnt", 64'(redirect_cnt), 64'(m_rc));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_sc));
    if (m_boot) begin
      m_boot = 0; m_left = 1 + WS;
    end else if (m_halted) begin
      // frozen until reset
    end else if (r) begin
      e_next = rr ? rt : bt; e_we = 1; e_fl = 1;
      m_rc = sat_inc(m_rc); m_stalled = 0; m_left = 1 + WS;
    end else if (h) begin
      m_halted = 1;
    end else if (m_stalled || m_left == 1) begin
      if (s) begin
        m_stalled = 1; m_sc = sat_inc(m_sc);
      end else begin
        e_next = m_pc + 64'd4; e_we = 1; e_ifid = 1;
        m_stalled = 0; m_left = 1 + WS; m_ic = sat_inc(m_ic);
      end
    end else begin
      m_left--;
    end
    chk("m_pc_we", 64'(pc_we), 64'(e_we));
    chk("m_pc_next", pc_next, e_next);
    chk("m_if_id_we", 64'(if_id_we), 64'(e_ifid));
    chk("m_if_id_flush", 64'(if_id_flush), 64'(e_fl));
    chk("m_id_ex_flush", 64'(id_ex_flush), 64'(e_fl));
    if (e_we) m_pc = e_next;
  endtask

  task automatic cycle_end();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle_begin(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    cycle_end();
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic pulse_reset();
    stall_req = 0; halt_req = 0; redirect = 0; redirect_reg = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(fetch_state), 64'(BOOT));
    chk("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    chk("rst_redirect_cnt", 64'(redirect_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_pc_we", 64'(pc_we), 64'd0);
    chk("rst_flush", 64'({if_id_we, if_id_flush, id_ex_flush}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s, h, r, rr;
    logic [63:0] bt, rt;
    logic [2:0]  st;
    logic        we;
    logic [63:0] nx;
    logic        ifid, fl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic h, input logic r, input logic rr,
                     input logic [63:0] bt, input logic [63:0] rt, input logic [2:0] st,
                     input logic we, input logic [63:0] nx, input logic ifid, input logic fl);
    vec_t v;
    v.s = s; v.h = h; v.r = r; v.rr = rr; v.bt = bt; v.rt = rt;
    v.st = st; v.we = we; v.nx = nx; v.ifid = ifid; v.fl = fl;
    tbl.push_back(v);
  endtask

  initial begin
    logic s, h, r, rr;
    logic [63:0] bt, rt;

    // Table: s h r rr bt rt | state we next ifid flush
    add(0,0,0,0, 64'h0,   64'h0,   BOOT,   0, 64'h0,   0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   FETCH,  0, 64'h0,   0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   WAIT,   0, 64'h0,   0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   WAIT,   1, 64'h4,   1, 0);
    add(0,0,0,0, 64'h0,   64'h0,   FETCH,  0, 64'h4,   0, 0);
    add(0,0,1,0, 64'h40,  64'h77,  WAIT,   1, 64'h40,  0, 1);
    add(0,0,0,0, 64'h0,   64'h0,   FETCH,  0, 64'h40,  0, 0);
    add(1,1,1,1, 64'h999, 64'h100, WAIT,   1, 64'h100, 0, 1);
    add(0,0,1,0, 64'h20,  64'h0,   FETCH,  1, 64'h20,  0, 1);
    add(0,0,0,0, 64'h0,   64'h0,   FETCH,  0, 64'h20,  0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   WAIT,   0, 64'h20,  0, 0);
    add(1,0,0,0, 64'h0,   64'h0,   WAIT,   0, 64'h20,  0, 0);
    add(1,0,0,0, 64'h0,   64'h0,   STALL,  0, 64'h20,  0, 0);
    add(1,0,0,0, 64'h0,   64'h0,   STALL,  0, 64'h20,  0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   STALL,  1, 64'h24,  1, 0);
    add(0,0,0,0, 64'h0,   64'h0,   FETCH,  0, 64'h24,  0, 0);
    add(0,1,0,0, 64'h0,   64'h0,   WAIT,   0, 64'h24,  0, 0);
    add(1,0,1,0, 64'h80,  64'h0,   HALTED, 0, 64'h24,  0, 0);
    add(0,0,0,0, 64'h0,   64'h0,   HALTED, 0, 64'h24,  0, 0);

    // Power-on reset
    rst_n = 1'b0;
    stall_req = 0; halt_req = 0; redirect = 0; redirect_reg = 0;
    br_target = 0; reg_target = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("por_state", 64'(fetch_state), 64'(BOOT));
    chk("por_enables", 64'({pc_we, if_id_we, if_id_flush, id_ex_flush}), 64'd0);
    chk("por_counters", 64'(stall_cnt | redirect_cnt | instr_cnt), 64'd0);
    chk("por_z_state", 64'(z_fetch_state), 64'(BOOT));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Zero-wait instance: BOOT then one sequential fetch per cycle.
    for (int i = 0; i < 6; i++) begin
      cycle_begin(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      if (i == 0) begin
        chk("z_boot_state", 64'(z_fetch_state), 64'(BOOT));
        chk("z_boot_pc_we", 64'(z_pc_we), 64'd0);
      end else begin
        chk("z_state", 64'(z_fetch_state), 64'(FETCH));
        chk("z_pc_we", 64'(z_pc_we), 64'd1);
        chk("z_if_id_we", 64'(z_if_id_we), 64'd1);
        chk("z_pc_next", z_pc_next, 64'(4 * i));
      end
      cycle_end();
    end
    #1;
    chk("z_instr_cnt", 64'(z_instr_cnt), 64'd5);

    // Table-driven corners on the two-wait-state instance.
    pulse_reset();
    foreach (tbl[i]) begin
      cycle_begin(tbl[i].s, tbl[i].h, tbl[i].r, tbl[i].rr, tbl[i].bt, tbl[i].rt);
      chk($sformatf("t%0d_state", i), 64'(fetch_state), 64'(tbl[i].st));
      chk($sformatf("t%0d_pc_we", i), 64'(pc_we), 64'(tbl[i].we));
      chk($sformatf("t%0d_pc_next", i), pc_next, tbl[i].nx);
      chk($sformatf("t%0d_if_id_we", i), 64'(if_id_we), 64'(tbl[i].ifid));
      chk($sformatf("t%0d_flushes", i), 64'({if_id_flush, id_ex_flush}),
          64'({tbl[i].fl, tbl[i].fl}));
      cycle_end();
    end
    #1;
    chk("tbl_instr_cnt", 64'(instr_cnt), 64'd2);
    chk("tbl_redirect_cnt", 64'(redirect_cnt), 64'd3);
    chk("tbl_stall_cnt", 64'(stall_cnt), 64'd3);

    // Reset out of HALTED, then 64-bit wrap, then reset in the middle of WAIT.
    pulse_reset();
    idle_cycle();                                                     // BOOT
    cycle_begin(1'b0, 1'b0, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_redirect", pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle_end();
    idle_cycle();                                                     // FETCH
    idle_cycle();                                                     // WAIT
    cycle_begin(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);                // WAIT, completes
    chk("wrap_pc_next", pc_next, 64'd0);
    chk("wrap_pc_we", 64'(pc_we), 64'd1);
    cycle_end();
    idle_cycle();                                                     // FETCH
    #1;
    chk("midwait_state", 64'(fetch_state), 64'(WAIT));
    chk("midwait_instr_cnt", 64'(instr_cnt), 64'd1);
    pulse_reset();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) begin
        pulse_reset();
      end else begin
        s  = ($urandom_range(0, 3) == 0);
        h  = ($urandom_range(0, 39) == 0);
        r  = ($urandom_range(0, 9) == 0);
        rr = 1'($urandom_range(0, 1));
        bt = {$urandom, $urandom} & ~64'h3;
        rt = {$urandom, $urandom} & ~64'h3;
        if ($urandom_range(0, 7) == 0) bt = 64'hFFFF_FFFF_FFFF_FFFC;
        if ($urandom_range(0, 7) == 0) rt = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle_begin(s, h, r, rr, bt, rt);
        cycle_end();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
